// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, master state enum and small helpers for the burst master.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    // AxSIZE encoding: log2 of the bus width in bytes.
    function automatic logic [2:0] axi_size(input int data_width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((data_width / 8) == (1 << i)) s = 3'(i);
        end
        return s;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_check.sv
// Combinational legality check for a burst command; only the low 12 address bits
// matter because alignment and 4 KB crossing are both decided inside one page.
module axi_burst_check
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic [11:0] addr_lo,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic        ok
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [20:0] span_end;
    logic        aligned;
    logic        len_ok;
    logic        burst_ok;

    always_comb begin
        span_end = 21'(addr_lo) + (21'(len) + 21'd1) * 21'(BYTES);
        aligned  = (addr_lo & 12'(BYTES - 1)) == 12'd0;
        len_ok   = (int'(len) + 1) <= MAX_BEATS;
        burst_ok = 1'b0;
        case (burst_t'(burst))
            BURST_FIXED: burst_ok = (len <= 8'd15);
            BURST_INCR:  burst_ok = (span_end <= 21'd4096);
            BURST_WRAP:  burst_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
            default:     burst_ok = 1'b0;
        endcase
        ok = aligned && len_ok && burst_ok;
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst master: command port plus write/read data streams, one transaction in flight.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// AW    | write address presented, waiting for awready
// W     | write beats streamed from wr_t* to w*
// B     | waiting for the write response
// AR    | read address presented, waiting for arready
// R     | read beats streamed from r* to rd_t*
// DONE  | one-cycle completion pulse with the worst response
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BEATS  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [1:0]              cmd_burst,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic                    wr_tvalid,
    output logic                    wr_tready,
    input  logic [DATA_WIDTH-1:0]   wr_tdata,
    input  logic [DATA_WIDTH/8-1:0] wr_tstrb,
    output logic                    rd_tvalid,
    input  logic                    rd_tready,
    output logic [DATA_WIDTH-1:0]   rd_tdata,
    output logic                    rd_tlast,
    output logic                    done_valid,
    output logic                    done_write,
    output logic [1:0]              done_resp,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam logic [2:0] SIZE = axi_size(DATA_WIDTH);

    state_t                state;
    state_t                state_nxt;
    logic                  cmd_ok;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  write_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_q;
    logic                  cmd_hs;
    logic                  w_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic [1:0]            r_resp_eff;

    axi_burst_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_check (
        .addr_lo (cmd_addr[11:0]),
        .len     (cmd_len),
        .burst   (cmd_burst),
        .ok      (cmd_ok)
    );

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign w_hs      = wvalid && wready;
    assign r_hs      = rvalid && rready;
    assign last_beat = (beat_cnt == len_q);

    // A protocol slip on a read beat (wrong id, rlast out of step) is reported as at least SLVERR.
    assign r_resp_eff = ((rid != id_q) || (rlast != last_beat)) ? resp_max(rresp, RESP_SLVERR) : rresp;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = !cmd_ok ? ST_DONE : (cmd_write ? ST_AW : ST_AR);
            ST_AW:   if (awready) state_nxt = ST_W;
            ST_W:    if (w_hs && last_beat) state_nxt = ST_B;
            ST_B:    if (bvalid) state_nxt = ST_DONE;
            ST_AR:   if (arready) state_nxt = ST_R;
            ST_R:    if (r_hs && last_beat) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == ST_IDLE);
        awvalid    = (state == ST_AW);
        wvalid     = (state == ST_W) && wr_tvalid;
        wr_tready  = (state == ST_W) && wready;
        wlast      = (state == ST_W) && last_beat;
        bready     = (state == ST_B);
        arvalid    = (state == ST_AR);
        rready     = (state == ST_R) && rd_tready;
        rd_tvalid  = (state == ST_R) && rvalid;
        rd_tlast   = (state == ST_R) && last_beat;
        done_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            id_q     <= '0;
            write_q  <= 1'b0;
            beat_cnt <= '0;
            resp_q   <= RESP_OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                burst_q  <= cmd_burst;
                id_q     <= cmd_id;
                write_q  <= cmd_write;
                beat_cnt <= '0;
                resp_q   <= cmd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_hs || r_hs) beat_cnt <= beat_cnt + 8'd1;
            if (bvalid && bready) resp_q <= (bid != id_q) ? RESP_SLVERR : bresp;
            if (r_hs) resp_q <= resp_max(resp_q, r_resp_eff);
        end
    end

    assign awid       = id_q;
    assign awaddr     = addr_q;
    assign awlen      = len_q;
    assign awsize     = SIZE;
    assign awburst    = burst_q;
    assign arid       = id_q;
    assign araddr     = addr_q;
    assign arlen      = len_q;
    assign arsize     = SIZE;
    assign arburst    = burst_q;
    assign wdata      = wr_tdata;
    assign wstrb      = wr_tstrb;
    assign rd_tdata   = rdata;
    assign done_write = write_q;
    assign done_resp  = resp_q;

endmodule
